echo_detector: RTL and testbench
================================

Name: echo_detector

Overview:
- Sits directly downstream of the constant-gain shift multiplier in the sonar receive chain.
- Consumes the amplified signed 16-bit sample stream and opens a measurement window on each ping start.
- Detects the first echo whose magnitude exceeds a programmable threshold for HOLD consecutive samples.
- Reports time-of-flight in sample counts, a hit flag and, optionally, the peak magnitude, for readout by the register bank.

Parameters:
- N, 16, sample width; data_i is signed two's complement.
- CNT_W, 16, width of the sample counter, blank, timeout and tof_o.
- HOLD, 4, consecutive over-threshold samples required to declare a hit (1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low forces IDLE
- start_i  input  1  one-cycle pulse that opens a measurement window
- valid_i  input  1  sample strobe; data_i is valid in this cycle
- data_i  input  N  signed amplified sample from the multiplier
- threshold_i  input  N  unsigned magnitude threshold
- blank_i  input  CNT_W  samples ignored after start (transducer ring-down)
- timeout_i  input  CNT_W  window length in samples
- busy_o  output  1  high in BLANK or LISTEN
- done_o  output  1  one-cycle pulse when a window ends (hit or timeout)
- hit_o  output  1  echo found in the last window
- tof_o  output  CNT_W  sample index of the first sample of the qualifying run
- peak_o  output  N  peak magnitude seen in LISTEN (optional feature)

Behaviour:
- Reset: state IDLE; busy_o, done_o, hit_o = 0; tof_o, peak_o, counters = 0.
- Magnitude: mag = |data_i| as N-bit unsigned. Most-negative input -32768 gives 0x8000; no saturation needed.
- Sample counter cnt: cleared on start_i and incremented on each valid_i in BLANK or LISTEN. The first sample after start has index 0.
- States:
  - IDLE: on start_i & en -> BLANK if blank_i != 0, else LISTEN. Clear cnt, run counter, peak, hit_o and tof_o.
  - BLANK: samples are counted but not compared. When a valid_i arrives with cnt == blank_i-1 -> LISTEN.
  - LISTEN: on each valid_i, if mag > threshold_i (strict), run++; otherwise run = 0. Record the index of the first sample of the current run. When run reaches HOLD: hit_o = 1, tof_o = recorded index, done_o pulse, -> IDLE.
  - Timeout: a valid_i with cnt == timeout_i-1 and no hit completes the window: hit_o = 0, tof_o = 0, done_o pulse, -> IDLE. This check also applies in BLANK, so blank_i >= timeout_i ends by timeout. A hit on that same sample takes priority over the timeout.
  - timeout_i == 0: window ends the cycle after start with hit_o = 0.
- Latency: done_o, hit_o and tof_o update on the clock edge after the deciding valid_i, i.e. 1 cycle. Results hold until the next start_i.
- start_i while busy aborts and restarts the window; no done_o for the aborted window.
- If start_i and valid_i are in the same cycle, that sample is not counted.
- en low in any state -> IDLE next cycle with no done_o. Result outputs hold their values.
- Inputs threshold_i, blank_i and timeout_i are sampled live; software changes them only while not busy.
- Asynchronous reset mid-window clears everything immediately.

Optional Feature:
- ECHO_PEAK_EN defined: peak_o tracks the maximum mag over valid LISTEN samples. It is cleared on start_i and frozen at done_o.
- ECHO_PEAK_EN undefined: peak_o is tied to 0 and the peak register and comparator are not built.

Decomposition:
- Package sscs_echo_pkg holds:
  - state enum: IDLE, BLANK, LISTEN;
  - default width constants: N = 16, CNT_W = 16;
  - HOLD counter width localparam: $clog2(HOLD+1).
- Sub-module abs_mag (N-bit signed -> N-bit unsigned magnitude, combinational) is instantiated once. The FSM, counters and result registers stay in echo_detector.

Test Plan:
- Hit case: threshold 1000, blank 10, timeout 200, HOLD 4, start, then a valid_i every cycle. Samples 0..49 are 0 and samples 50..53 are +1500 -> done_o 1 cycle after sample 53, hit_o = 1, tof_o = 50.
- Blanking: same setup, but samples 0..9 are 30000 and the rest 0 -> no hit, done_o after sample 199, hit_o = 0, tof_o = 0.
- Run broken: samples 60..62 = -2000, 63 = 0, 64..67 = -32768 -> hit_o = 1, tof_o = 64. With ECHO_PEAK_EN, peak_o = 0x8000.
- Restart: start at t0, start again after 30 samples, echo placed at sample 40 of the new window -> exactly one done_o, tof_o = 40.
- Edges:
  - threshold exactly 1000 with samples = 1000 -> never hits;
  - timeout_i = 0 -> done_o the cycle after start with hit_o = 0;
  - en dropped mid-LISTEN -> busy_o = 0 next cycle, no done_o.
- Asynchronous reset: assert rst_n = 0 mid-window between clock edges -> busy_o, hit_o and tof_o are 0 immediately. The block then accepts a new start_i.

Source files
------------

// File: rtl/echo_detector_pkg.sv
// sscs_echo_pkg: shared types and default widths for the sonar echo detector.
package sscs_echo_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;

   localparam int N_DEF    = 16;
   localparam int CNT_DEF  = 16;
   localparam int HOLD_DEF = 4;
   localparam int RUN_W    = $clog2(HOLD_DEF + 1);

   function automatic int run_width(input int hold);
      return $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/echo_detector_abs_mag.sv
// abs_mag: combinational magnitude of a signed sample; -2^(N-1) maps to 2^(N-1).
module abs_mag
   import sscs_echo_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic signed [N-1:0] a,
   output logic        [N-1:0] m
);

   assign m = a[N-1] ? N'(-a) : N'(a);

endmodule

// File: rtl/echo_detector.sv
// echo_detector: opens a window on each ping start and reports the first echo run of HOLD samples.
// Define ECHO_PEAK_EN to build the peak-magnitude tracker behind peak_o.
module echo_detector
   import sscs_echo_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_DEF,
   parameter int HOLD  = HOLD_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                start_i,
   input  logic                valid_i,
   input  logic signed [N-1:0] data_i,
   input  logic [N-1:0]        threshold_i,
   input  logic [CNT_W-1:0]    blank_i,
   input  logic [CNT_W-1:0]    timeout_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                hit_o,
   output logic [CNT_W-1:0]    tof_o,
   output logic [N-1:0]        peak_o
);

   localparam int RW = run_width(HOLD);

   state_t           state;
   logic [CNT_W-1:0] cnt, first;
   logic [RW-1:0]    run;
   logic [N-1:0]     mag;
   logic             step, over, last, hit;

   abs_mag #(.N(N)) u_mag (.a(data_i), .m(mag));

   // a start in the same cycle as a sample wins, so that sample is not counted
   assign step = en && !start_i && valid_i && state != IDLE;
   assign over = mag > threshold_i;
   assign last = cnt == timeout_i - CNT_W'(1);
   assign hit  = state == LISTEN && over && run == RW'(HOLD - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         first  <= '0;
         run    <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         hit_o  <= 1'b0;
         tof_o  <= '0;
      end else begin
         done_o <= 1'b0;
         if (!en) begin
            state  <= IDLE;
            busy_o <= 1'b0;
         end else if (start_i) begin
            cnt   <= '0;
            first <= '0;
            run   <= '0;
            hit_o <= 1'b0;
            tof_o <= '0;
            // a zero-length window completes immediately without a hit
            if (timeout_i == '0) begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end else begin
               state  <= blank_i != '0 ? BLANK : LISTEN;
               busy_o <= 1'b1;
            end
         end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (state == LISTEN) begin
               run <= over ? run + RW'(1) : '0;
               if (over && run == '0) first <= cnt;
            end
            if (hit || last) begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
               hit_o  <= hit;
               tof_o  <= hit ? (run == '0 ? cnt : first) : '0;
            end else if (state == BLANK && cnt == blank_i - CNT_W'(1)) begin
               state <= LISTEN;
            end
         end
      end

`ifdef ECHO_PEAK_EN
   logic [N-1:0] peak;

   // LISTEN ends at done, so the peak freezes with the result
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         peak <= '0;
      else if (en && start_i)
         peak <= '0;
      else if (step && state == LISTEN && mag > peak)
         peak <= mag;

   assign peak_o = peak;
`else
   assign peak_o = '0;
`endif

endmodule

// File: tb/tb_echo_detector.sv
// tb_echo_detector: directed and randomized windows checked against a window-search reference model.
module tb_echo_detector;

   localparam int N    = 16;
   localparam int CW   = 16;
   localparam int HOLD = 4;

   logic                clk = 1'b0, rst_n = 1'b0, en = 1'b1, start_i = 1'b0, valid_i = 1'b0;
   logic signed [N-1:0] data_i = '0;
   logic [N-1:0]        threshold_i = '0;
   logic [CW-1:0]       blank_i = '0, timeout_i = '0;
   logic                busy_o, done_o, hit_o;
   logic [CW-1:0]       tof_o;
   logic [N-1:0]        peak_o;

   logic signed [N-1:0] smp [0:299];
   int npass = 0, nfail = 0, nchk = 0;

   echo_detector #(.N(N), .CNT_W(CW), .HOLD(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start_i(start_i), .valid_i(valid_i),
      .data_i(data_i), .threshold_i(threshold_i), .blank_i(blank_i), .timeout_i(timeout_i),
      .busy_o(busy_o), .done_o(done_o), .hit_o(hit_o), .tof_o(tof_o), .peak_o(peak_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish, required finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
      nchk++;
      assert (obs === ex) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, ex);
      end
   endtask

   function automatic int magi(input logic signed [N-1:0] v);
      return v < 0 ? -int'(v) : int'(v);
   endfunction

   // first start index s >= blank whose HOLD samples all exceed th and finish inside the window
   function automatic void model(input int b, input int t, input int th,
                                 output bit h, output int tof, output int last, output int pk);
      bit ok;
      h = 0; tof = 0; last = t - 1;
      for (int s = b; s + HOLD - 1 < t && !h; s++) begin
         ok = 1;
         for (int k = 0; k < HOLD; k++) if (magi(smp[s+k]) <= th) ok = 0;
         if (ok) begin h = 1; tof = s; last = s + HOLD - 1; end
      end
      pk = 0;
      for (int j = b; j <= last; j++) if (magi(smp[j]) > pk) pk = magi(smp[j]);
   endfunction

   task automatic fill(input int v);
      for (int j = 0; j < 300; j++) smp[j] = N'(v);
   endtask

   task automatic start_win(input int b, input int t, input int th);
      blank_i = CW'(b); timeout_i = CW'(t); threshold_i = N'(th);
      start_i = 1'b1; valid_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic feed(input int n, output int dones);
      dones = 0;
      for (int k = 0; k < n; k++) begin
         valid_i = 1'b1; data_i = smp[k];
         @(posedge clk); #1;
         if (done_o) dones++;
      end
      valid_i = 1'b0;
   endtask

   task automatic play(input int b, input int t, input int th, input int gap, input string tag);
      bit h;
      int tof, last, pk, i, got;
      model(b, t, th, h, tof, last, pk);
      start_win(b, t, th);
      if (t == 0) begin
         chk({tag, " t0 done"}, 32'(done_o), 1);
         chk({tag, " t0 hit"}, 32'(hit_o), 0);
         chk({tag, " t0 busy"}, 32'(busy_o), 0);
         return;
      end
      chk({tag, " busy"}, 32'(busy_o), 1);
      i = 0; got = -1;
      for (int c = 0; c < 1000 && got == -1; c++) begin
         valid_i = ($urandom_range(99) >= gap);
         data_i  = valid_i ? smp[i % 300] : '0;
         @(posedge clk); #1;
         if (done_o) got = valid_i ? i : -2;
         if (valid_i) i++;
      end
      valid_i = 1'b0;
      chk({tag, " end sample"}, 32'(got), 32'(last));
      chk({tag, " hit"}, 32'(hit_o), 32'(h));
      chk({tag, " tof"}, 32'(tof_o), 32'(tof));
      chk({tag, " idle"}, 32'(busy_o), 0);
`ifdef ECHO_PEAK_EN
      chk({tag, " peak"}, 32'(peak_o), 32'(pk));
`else
      chk({tag, " peak"}, 32'(peak_o), 0);
`endif
      @(posedge clk); #1;
      chk({tag, " done pulse"}, 32'(done_o), 0);
      chk({tag, " hit held"}, 32'(hit_o), 32'(h));
   endtask

   initial begin
      int d;
      logic signed [N-1:0] r;
      int b, t, th;
      #1;
      chk("reset busy", 32'(busy_o), 0);
      chk("reset done", 32'(done_o), 0);
      chk("reset hit", 32'(hit_o), 0);
      chk("reset tof", 32'(tof_o), 0);
      chk("reset peak", 32'(peak_o), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      fill(0);
      for (int j = 50; j < 54; j++) smp[j] = 16'sd1500;
      play(10, 200, 1000, 0, "hit");

      @(negedge clk); rst_n = 1'b0; #1;
      chk("held reset hit", 32'(hit_o), 0);
      chk("held reset tof", 32'(tof_o), 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      fill(0);
      for (int j = 0; j < 10; j++) smp[j] = 16'sd30000;
      play(10, 200, 1000, 0, "blank");

      fill(0);
      for (int j = 60; j < 63; j++) smp[j] = -16'sd2000;
      for (int j = 64; j < 68; j++) smp[j] = -16'sd32768;
      play(10, 200, 1000, 0, "run");

      fill(0);
      start_win(10, 200, 1000);
      feed(30, d);
      chk("restart early done", 32'(d), 0);
      for (int j = 40; j < 44; j++) smp[j] = 16'sd1500;
      play(10, 200, 1000, 0, "restart");

      fill(1000);
      play(0, 50, 1000, 0, "thr_eq");

      play(10, 0, 1000, 0, "t0");

      fill(0);
      start_win(5, 200, 1000);
      feed(20, d);
      en = 1'b0;
      @(posedge clk); #1;
      chk("en drop busy", 32'(busy_o), 0);
      chk("en drop done", 32'(done_o), 0);
      en = 1'b1;
      @(posedge clk); #1;
      chk("en drop done later", 32'(done_o), 0);
      chk("en drop stays idle", 32'(busy_o), 0);

      start_win(0, 200, 1000);
      feed(10, d);
      @(negedge clk); rst_n = 1'b0; #1;
      chk("async busy", 32'(busy_o), 0);
      chk("async hit", 32'(hit_o), 0);
      chk("async tof", 32'(tof_o), 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int j = 50; j < 54; j++) smp[j] = 16'sd1500;
      play(10, 200, 1000, 0, "post reset");

      for (int w = 0; w < 25; w++) begin
         for (int j = 0; j < 300; j++) begin
            r = N'($urandom);
            smp[j] = r >>> $urandom_range(0, 6);
         end
         b  = $urandom_range(0, 20);
         t  = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 80);
         th = $urandom_range(200, 8000);
         play(b, t, th, 30, $sformatf("rand%0d", w));
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
